// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the CPU data-memory port.
//
// Accepts one load/store at a time from the MEM stage and completes it against
// the Ram1 SRAM or the memory-mapped UART. The strobe of an external access is
// held low for WAIT_CYCLES+1 cycles. A one-cycle ack_o pulse ends each access.
//
// Build option: define ZZ_UART_MAP_EN to decode the UART data and status
// addresses. Without it, every address goes to the SRAM, rdn/wrn stay high and
// tbre/tsre/data_ready are ignored.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_i, we_i         request (held until ack_o); 1 = store, 0 = load
//   addr_i, wdata_i     16-bit word address and store data
//   rdata_o             load result, valid with ack_o and held afterwards
//   ack_o, busy_o       completion pulse; high from acceptance through ack
//   Ram1Addr/Data       SRAM address and shared SRAM/UART data bus
//   Ram1OE/WE/EN        SRAM strobes, active-low
//   rdn, wrn            UART read/write strobes, active-low
//   tbre, tsre          UART transmit buffer / shift register empty
//   data_ready          UART receive data available
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSacc, StUacc, StAck} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [15:0]       r_addr, w_addr_d;
  logic [15:0]       r_wdata, w_wdata_d;
  logic [15:0]       r_rdata, w_rdata_d;
  logic              r_we, w_we_d;
  logic              r_ext, w_ext_d;  // access touches the external bus
  logic              r_busy;
  logic              w_bus_drive;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_ext   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_rdata <= w_rdata_d;
      r_we    <= w_we_d;
      r_ext   <= w_ext_d;
      r_busy  <= (w_state_d != StIdle);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    w_we_d    = r_we;
    w_ext_d   = r_ext;

    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_addr_d  = addr_i;
          w_wdata_d = wdata_i;
          w_we_d    = we_i;
          w_ext_d   = 1'b1;
          w_cnt_d   = CntW'(WAIT_CYCLES);
          w_state_d = StSacc;
`ifdef ZZ_UART_MAP_EN
          if (addr_i == UART_STAT_ADDR) begin
            // Status is answered from the inputs at the accepting edge; no bus cycle.
            w_ext_d   = 1'b0;
            w_state_d = StAck;
            if (!we_i) begin
              w_rdata_d = {14'b0, data_ready, tbre & tsre};
            end
          end else if (addr_i == UART_DATA_ADDR) begin
            w_state_d = StUacc;
          end
`endif
        end
      end

      StSacc, StUacc: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CntW'(1);
        end else begin
          if (!r_we) begin
            w_rdata_d = Ram1Data;
          end
          w_state_d = StAck;
        end
      end

      StAck: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Store data stays on the bus through the ack cycle for hold time.
  assign w_bus_drive = r_we && r_ext && (r_state != StIdle);
  assign Ram1Data    = w_bus_drive ? r_wdata : 16'hzzzz;

  assign Ram1Addr = {2'b00, r_addr};
  assign Ram1EN   = ~(r_state == StSacc);
  assign Ram1OE   = ~((r_state == StSacc) && !r_we);
  assign Ram1WE   = ~((r_state == StSacc) && r_we);

`ifdef ZZ_UART_MAP_EN
  assign rdn = ~((r_state == StUacc) && !r_we);
  assign wrn = ~((r_state == StUacc) && r_we);
`else
  assign rdn = 1'b1;
  assign wrn = 1'b1;
  // UART status inputs and addresses have no function in this build.
  logic w_unused;
  assign w_unused = ^{tbre, tsre, data_ready, UART_DATA_ADDR, UART_STAT_ADDR};
`endif

  assign ack_o   = (r_state == StAck);
  assign busy_o  = r_busy;
  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES = 1).
// The driver pushes the expected response of every request; the monitor counts
// strobe cycles and pops/compares on each ack_o.
module tb_dmem_responder;

`ifdef ZZ_UART_MAP_EN
  localparam bit UartMap = 1'b1;
`else
  localparam bit UartMap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic [17:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        ram1_oe, ram1_we, ram1_en;
  logic        rdn, wrn;
  logic        tbre, tsre, data_ready;
  logic        model_clr;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .WAIT_CYCLES   (1),
    .UART_DATA_ADDR(16'hBF00),
    .UART_STAT_ADDR(16'hBF01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .ack_o     (ack),
    .busy_o    (busy),
    .Ram1Addr  (ram1_addr),
    .Ram1Data  (ram1_data),
    .Ram1OE    (ram1_oe),
    .Ram1WE    (ram1_we),
    .Ram1EN    (ram1_en),
    .rdn       (rdn),
    .wrn       (wrn),
    .tbre      (tbre),
    .tsre      (tsre),
    .data_ready(data_ready)
  );

  // SRAM model: 256 words by low address byte; unwritten words read 0xA5xx.
  logic [15:0]  mem [256];
  logic [255:0] mem_vld;
  logic [15:0]  sram_rd;

  always @(posedge clk) begin
    if (model_clr) begin
      mem_vld <= '0;
    end else if (!ram1_en && !ram1_we) begin
      mem[ram1_addr[7:0]]     <= ram1_data;
      mem_vld[ram1_addr[7:0]] <= 1'b1;
    end
  end

  assign sram_rd   = mem_vld[ram1_addr[7:0]] ? mem[ram1_addr[7:0]]
                                             : (16'hA500 | {8'h00, ram1_addr[7:0]});
  assign ram1_data = (!ram1_oe && !ram1_en) ? sram_rd : 16'hzzzz;
  assign ram1_data = (!rdn) ? 16'h00A5 : 16'hzzzz;

  typedef struct {
    int unsigned cyc;
    logic        chk_rd;
    logic [15:0] rd;
    int          n_we, n_oe, n_rdn, n_wrn, n_en;
    logic [17:0] addr;
    logic [15:0] wd;
    logic        chk_wr;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin
    int n_we, n_oe, n_rdn, n_wrn, n_en;
    logic [17:0] seen_addr;
    logic [15:0] seen_wd;
    exp_t e;
    n_we = 0; n_oe = 0; n_rdn = 0; n_wrn = 0; n_en = 0;
    seen_addr = '0; seen_wd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_we = 0; n_oe = 0; n_rdn = 0; n_wrn = 0; n_en = 0;
      end else begin
        if (!ram1_we) n_we++;
        if (!ram1_oe) n_oe++;
        if (!rdn) n_rdn++;
        if (!wrn) n_wrn++;
        if (!ram1_en) begin
          n_en++;
          seen_addr = ram1_addr;
        end
        if (!ram1_we || !wrn) seen_wd = ram1_data;
        if (ack) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
          end else begin
            e = sb.pop_front();
            check("ack_cycle", cyc, e.cyc);
            check("busy_at_ack", {31'b0, busy}, 32'd1);
            check("we_low_cycles", n_we, e.n_we);
            check("oe_low_cycles", n_oe, e.n_oe);
            check("rdn_low_cycles", n_rdn, e.n_rdn);
            check("wrn_low_cycles", n_wrn, e.n_wrn);
            check("en_low_cycles", n_en, e.n_en);
            if (e.chk_rd) check("rdata", {16'b0, rdata}, {16'b0, e.rd});
            if (e.n_en > 0) check("ram1_addr", {14'b0, seen_addr}, {14'b0, e.addr});
            if (e.chk_wr) check("store_data", {16'b0, seen_wd}, {16'b0, e.wd});
          end
          n_we = 0; n_oe = 0; n_rdn = 0; n_wrn = 0; n_en = 0;
        end
      end
    end
  end

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_%s: got no ack in 20 cycles, required one", tag);
    end
  endtask

  // Entered and left on a negedge; the DUT is idle on entry.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input int nwe, input int noe, input int nrdn,
                        input int nwrn, input int nen, input logic [15:0] erd);
    exp_t e;
    we    = w;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    e.cyc    = cyc + 1 + lat;
    e.chk_rd = !w;
    e.rd     = erd;
    e.n_we   = nwe;
    e.n_oe   = noe;
    e.n_rdn  = nrdn;
    e.n_wrn  = nwrn;
    e.n_en   = nen;
    e.addr   = {2'b00, a};
    e.wd     = d;
    e.chk_wr = w && ((nwe + nwrn) > 0);
    sb.push_back(e);
    wait_ack("req");
    req = 1'b0;
    @(negedge clk);
    check("busy_after_ack", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; model_clr = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdata", {16'b0, rdata}, 32'd0);
    check("rst_strobes", {27'b0, ram1_oe, ram1_we, ram1_en, rdn, wrn}, 32'h1F);
    check("rst_addr", {14'b0, ram1_addr}, 32'd0);
    rst = 1'b0; model_clr = 1'b0;
    @(negedge clk);

    // SRAM store and load back
    do_req(1'b1, 16'h0040, 16'h1234, 2, 2, 0, 0, 0, 2, 16'h0000);
    do_req(1'b0, 16'h0040, 16'h0000, 2, 0, 2, 0, 0, 2, 16'h1234);

    // Status reads
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b1;
    do_req(1'b0, 16'hBF01, 16'h0000, UartMap ? 0 : 2, 0, UartMap ? 0 : 2, 0, 0,
           UartMap ? 0 : 2, UartMap ? 16'h0003 : 16'hA501);
    tsre = 1'b0;
    do_req(1'b0, 16'hBF01, 16'h0000, UartMap ? 0 : 2, 0, UartMap ? 0 : 2, 0, 0,
           UartMap ? 0 : 2, UartMap ? 16'h0002 : 16'hA501);

    // UART data write, then data read
    do_req(1'b1, 16'hBF00, 16'h0041, 2, UartMap ? 0 : 2, 0, 0, UartMap ? 2 : 0,
           UartMap ? 0 : 2, 16'h0000);
    do_req(1'b0, 16'hBF00, 16'h0000, 2, 0, UartMap ? 0 : 2, UartMap ? 2 : 0, 0,
           UartMap ? 0 : 2, UartMap ? 16'h00A5 : 16'h0041);

    // Status write: acked, no bus activity when UART mapped
    do_req(1'b1, 16'hBF01, 16'hFFFF, UartMap ? 0 : 2, UartMap ? 0 : 2, 0, 0, 0,
           UartMap ? 0 : 2, 16'h0000);

    // Top of the address space
    do_req(1'b1, 16'hFFFF, 16'hBEEF, 2, 2, 0, 0, 0, 2, 16'h0000);
    do_req(1'b0, 16'hFFFF, 16'h0000, 2, 0, 2, 0, 0, 2, 16'hBEEF);

    // Back-to-back with req held high
    we = 1'b0; addr = 16'h0040; req = 1'b1;
    e = '{cyc: cyc + 3, chk_rd: 1'b1, rd: 16'h1234, n_we: 0, n_oe: 2, n_rdn: 0,
          n_wrn: 0, n_en: 2, addr: 18'h00040, wd: 16'h0000, chk_wr: 1'b0};
    sb.push_back(e);
    wait_ack("b2b_first");
    addr = 16'hFFFF;
    e = '{cyc: cyc + 4, chk_rd: 1'b1, rd: 16'hBEEF, n_we: 0, n_oe: 2, n_rdn: 0,
          n_wrn: 0, n_en: 2, addr: 18'h0FFFF, wd: 16'h0000, chk_wr: 1'b0};
    sb.push_back(e);
    @(negedge clk);
    check("b2b_idle_gap", {31'b0, busy}, 32'd0);
    wait_ack("b2b_second");
    req = 1'b0;
    @(negedge clk);

    // Reset during the second SACC cycle of a store
    we = 1'b1; addr = 16'h0050; wdata = 16'h5555; req = 1'b1;
    @(negedge clk);
    check("mid_store_we_low", {31'b0, ram1_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("mid_rst_strobes", {27'b0, ram1_oe, ram1_we, ram1_en, rdn, wrn}, 32'h1F);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ack", {31'b0, ack}, 32'd0);
    check("mid_rst_rdata", {16'b0, rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_ack", {31'b0, ack}, 32'd0);

    // Recovery after reset
    do_req(1'b0, 16'h0040, 16'h0000, 2, 0, 2, 0, 0, 2, 16'h1234);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the CPU data-memory port: accepts single load/store requests from the MEM stage and completes them against the Ram1 SRAM and the memory-mapped UART.
- Sequences the off-chip strobes (Ram1OE/WE/EN, rdn, wrn) with a configurable access width.
- Returns read data with a one-cycle acknowledge pulse.

Parameters:
- WAIT_CYCLES, 1: extra strobe cycles per external access; strobe is active for WAIT_CYCLES+1 cycles.
- UART_DATA_ADDR, 16'hBF00: UART data register address.
- UART_STAT_ADDR, 16'hBF01: UART status register address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_i  in  1  access request, held by initiator until ack_o
- we_i  in  1  1 = store, 0 = load
- addr_i  in  16  word address
- wdata_i  in  16  store data
- rdata_o  out  16  load result, valid while ack_o=1, held afterwards
- ack_o  out  1  one-cycle completion pulse
- busy_o  out  1  high from acceptance through the ack cycle
- Ram1Addr  out  18  SRAM address
- Ram1Data  inout  16  shared SRAM/UART data bus
- Ram1OE  out  1  SRAM output enable, active-low
- Ram1WE  out  1  SRAM write enable, active-low
- Ram1EN  out  1  SRAM chip enable, active-low
- rdn  out  1  UART read strobe, active-low
- wrn  out  1  UART write strobe, active-low
- tbre  in  1  UART transmit buffer empty
- tsre  in  1  UART transmit shift register empty
- data_ready  in  1  UART receive data available

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; ack_o=0; busy_o=0; rdata_o=0; Ram1OE=Ram1WE=Ram1EN=1; rdn=wrn=1; Ram1Addr=0; Ram1Data=Z.
- States:
  - IDLE: req_i is sampled only here. When req_i=1, latch addr/we/wdata and decode the target:
    - addr==UART_STAT_ADDR -> ACK
    - addr==UART_DATA_ADDR -> UACC
    - all other addresses -> SACC
    - On entry to SACC/UACC, cnt=WAIT_CYCLES.
  - SACC: Ram1EN=0; Ram1Addr={2'b00,addr}.
    - Load: Ram1OE=0, bus Z.
    - Store: Ram1WE=0, Ram1Data driven with wdata.
  - UACC: Ram1EN=1.
    - Load: rdn=0.
    - Store: wrn=0, Ram1Data driven with wdata.
  - In SACC/UACC: if cnt!=0, cnt decrements. If cnt==0, a load captures Ram1Data into rdata_o at that edge, then -> ACK.
  - ACK: ack_o=1 and all strobes inactive. Store data remains driven during this cycle for hold time. Next state is IDLE.
- Status read: rdata_o={14'b0, data_ready, tbre&tsre}, sampled on the accepting edge. Ack appears the cycle after acceptance.
- Status write: ignored, but still acked.
- Latency:
  - req_i sampled at edge k.
  - External access: ack_o high in the cycle after edge k+WAIT_CYCLES+1.
  - Status access: ack_o high in the cycle after edge k.
- busy_o is registered: 1 in SACC/UACC/ACK, 0 in IDLE.
- Back-to-back requests: req_i seen during ACK is not accepted. The earliest next acceptance is the first IDLE cycle, giving at least one idle cycle between accesses.
- Bus ownership: Ram1Data is driven only for stores in SACC/UACC/ACK, otherwise Z. rdn and OE are never low while the bus is driven.
- Mid-operation reset: IDLE at the next edge, all strobes inactive, no ack issued, rdata_o cleared.
- Address bits [17:16] are always 0. All 16-bit addresses other than the two UART addresses map to SRAM.

Optional Feature:
- ZZ_UART_MAP_EN
  - Defined: UART decode as described above.
  - Undefined:
    - All addresses, including 0xBF00/0xBF01, go to SACC.
    - rdn and wrn are held at constant 1.
    - tbre, tsre and data_ready are unused.

Test Plan:
- Store 0x1234 to 0x0040, WAIT_CYCLES=1 -> Ram1WE low exactly 2 cycles, Ram1Addr=0x00040, Ram1Data=0x1234, single ack pulse, Ram1OE stays 1.
- Load 0x0040 with SRAM model returning 0x1234 -> rdata_o=0x1234 when ack_o=1; Ram1Data is Z throughout; ack arrives 2 edges after acceptance.
- Status read with tbre=1, tsre=1, data_ready=1 -> rdata_o=0x0003, ack in the cycle after acceptance, no strobe toggles.
- UART write 0x0041 to 0xBF00 -> wrn low 2 cycles, Ram1EN=1, Ram1Data=0x0041. Repeat with ZZ_UART_MAP_EN undefined -> Ram1WE low instead, wrn stays 1.
- rst asserted during the second SACC cycle of a store -> next cycle all strobes 1, Ram1Data Z, busy_o=0, no ack.
- req_i held high continuously over two requests -> second acceptance occurs one cycle after ack, with exactly one IDLE cycle between accesses.
